// File: rtl/cordic_job_sched.sv
// Two-requester round-robin scheduler feeding one shared iterative hyperbolic CORDIC core.
// Latency: accept->core_start 1 cycle; core_done->rsp_valid 1 cycle; illegal sn -> rsp_valid 1 cycle after accept.
// Backpressure: one job in flight; both req readys stay low until the response is taken (rsp_valid && rsp_ready).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   req{0,1}_*            job sources: valid/ready handshake, x/y/theta operands, sn select
//   core_*                operands + start pulse to the core; done + results back from the core
//   rsp_*                 response channel: valid/ready, requester id, results, error flag
//   busy                  high whenever a job is being handled (any state but IDLE)
module cordic_job_sched #(
   parameter int W       = 16,
   parameter int SNW     = 4,
   parameter int TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           reset,

   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_x,
   input  logic [W-1:0]   req0_y,
   input  logic [W-1:0]   req0_theta,
   input  logic [SNW-1:0] req0_sn,

   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_x,
   input  logic [W-1:0]   req1_y,
   input  logic [W-1:0]   req1_theta,
   input  logic [SNW-1:0] req1_sn,

   output logic           core_start,
   output logic [W-1:0]   core_x,
   output logic [W-1:0]   core_y,
   output logic [W-1:0]   core_theta,
   output logic [SNW-1:0] core_sn,
   input  logic           core_done,
   input  logic [W-1:0]   core_xo,
   input  logic [W-1:0]   core_yo,
   input  logic [W-1:0]   core_theta_o,

   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_x,
   output logic [W-1:0]   rsp_y,
   output logic [W-1:0]   rsp_theta,
   output logic           rsp_err,

   output logic           busy
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   logic            last_grant;
   logic [CW-1:0]   wd_cnt;

   logic            grant0;
   logic            grant1;
   logic            accept;
   logic            sel_id;
   logic [W-1:0]    acc_x;
   logic [W-1:0]    acc_y;
   logic [W-1:0]    acc_theta;
   logic [SNW-1:0]  acc_sn;

   // On a tie the requester that was not served last wins; last_grant
   // resets to 1 so requester 0 wins the first tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         if (last_grant) grant0 = 1'b1;
         else            grant1 = 1'b1;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   // Readys are gated by reset so nothing looks accepted while reset is held.
   assign req0_ready = reset && (state == S_IDLE) && grant0;
   assign req1_ready = reset && (state == S_IDLE) && grant1;
   assign accept     = req0_ready || req1_ready;
   assign sel_id     = grant1;

   assign acc_x     = sel_id ? req1_x     : req0_x;
   assign acc_y     = sel_id ? req1_y     : req0_y;
   assign acc_theta = sel_id ? req1_theta : req0_theta;
   assign acc_sn    = sel_id ? req1_sn    : req0_sn;

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         wd_cnt     <= '0;
         core_start <= 1'b0;
         core_x     <= '0;
         core_y     <= '0;
         core_theta <= '0;
         core_sn    <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_x      <= '0;
         rsp_y      <= '0;
         rsp_theta  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               core_start <= 1'b0;
               if (accept) begin
                  core_x     <= acc_x;
                  core_y     <= acc_y;
                  core_theta <= acc_theta;
                  core_sn    <= acc_sn;
                  rsp_id     <= sel_id;
                  if (acc_sn == '0) begin
                     // sn of zero is not a valid iteration count: answer
                     // straight away with an error and keep the core idle.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_x     <= '0;
                     rsp_y     <= '0;
                     rsp_theta <= '0;
                     state     <= S_RESP;
                  end else begin
                     core_start <= 1'b1;
                     state      <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               core_start <= 1'b0;
               wd_cnt     <= '0;
               state      <= S_WAIT;
            end

            S_WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               // core_done takes priority over an expiring watchdog.
               if (core_done) begin
                  rsp_x     <= core_xo;
                  rsp_y     <= core_yo;
                  rsp_theta <= core_theta_o;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  rsp_x     <= '0;
                  rsp_y     <= '0;
                  rsp_theta <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  last_grant <= rsp_id;
                  state      <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_job_sched.sv
// Directed bench for cordic_job_sched: inputs driven and outputs sampled
// around the falling clock edge; the core is emulated inline by each task.
module tb_cordic_job_sched;
   localparam int W       = 16;
   localparam int SNW     = 4;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]   req0_x, req0_y, req0_theta, req1_x, req1_y, req1_theta;
   logic [SNW-1:0] req0_sn, req1_sn;
   logic           core_start, core_done;
   logic [W-1:0]   core_x, core_y, core_theta, core_xo, core_yo, core_theta_o;
   logic [SNW-1:0] core_sn;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [W-1:0]   rsp_x, rsp_y, rsp_theta;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   cordic_job_sched #(.W(W), .SNW(SNW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
      .req0_theta(req0_theta), .req0_sn(req0_sn),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
      .req1_theta(req1_theta), .req1_sn(req1_sn),
      .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_theta(core_theta),
      .core_sn(core_sn), .core_done(core_done), .core_xo(core_xo), .core_yo(core_yo),
      .core_theta_o(core_theta_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_x(rsp_x),
      .rsp_y(rsp_y), .rsp_theta(rsp_theta), .rsp_err(rsp_err), .busy(busy)
   );

   // One count per cycle that core_start is high.
   always @(negedge clk) if (core_start === 1'b1) start_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic test_reset;
      reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
      checks++; if (core_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl got start=%b vld=%b busy=%b exp 0 0 0", core_start, rsp_valid, busy); end
      checks++; if (rsp_err !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags got err=%b id=%b exp 0 0", rsp_err, rsp_id); end
      checks++; if (core_x !== '0 || core_sn !== '0 || rsp_x !== '0 || rsp_theta !== '0) begin errors++; $display("FAIL reset_data got core_x=%h core_sn=%h rsp_x=%h rsp_th=%h exp 0", core_x, core_sn, rsp_x, rsp_theta); end
      req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      int s0;
      logic ok;
      req0_x = 16'h8000; req0_y = 16'h0000; req0_theta = 16'h1000; req0_sn = 4'd3; req0_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant got %b%b exp r0=1 r1=0", req0_ready, req1_ready); end
      s0 = start_cnt;
      @(negedge clk); req0_valid = 1'b0; #1;
      checks++; if (core_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_start got start=%b busy=%b exp 1 1", core_start, busy); end
      checks++; if (core_x !== 16'h8000 || core_theta !== 16'h1000 || core_sn !== 4'd3) begin errors++; $display("FAIL single_operands got %h %h %h exp 8000 1000 3", core_x, core_theta, core_sn); end
      ok = 1'b1;
      repeat (10) begin @(negedge clk); #1; if (rsp_valid !== 1'b0 || core_start !== 1'b0) ok = 1'b0; end
      @(negedge clk);
      core_done = 1'b1; core_xo = 16'h9A3C; core_yo = 16'h1234; core_theta_o = 16'h0042;
      #1; if (rsp_valid !== 1'b0) ok = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_quiet got glitch=%b exp no rsp/start before done", ~ok); end
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp got vld=%b id=%b err=%b exp 1 0 0", rsp_valid, rsp_id, rsp_err); end
      checks++; if (rsp_x !== 16'h9A3C || rsp_y !== 16'h1234 || rsp_theta !== 16'h0042) begin errors++; $display("FAIL single_data got %h %h %h exp 9a3c 1234 0042", rsp_x, rsp_y, rsp_theta); end
      checks++; if (start_cnt !== s0 + 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", start_cnt - s0); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got vld=%b busy=%b exp 0 0", rsp_valid, busy); end
   endtask

   task automatic test_contention;
      int waited;
      logic exp_id;
      reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      req0_x = 16'h1111; req0_y = 16'h0101; req0_theta = 16'h0011; req0_sn = 4'd5;
      req1_x = 16'h2222; req1_y = 16'h0202; req1_theta = 16'h0022; req1_sn = 4'd6;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         exp_id = j[0];
         waited = 0;
         #1;
         while (!(req0_ready || req1_ready) && waited < 8) begin @(negedge clk); #1; waited++; end
         checks++; if (req1_ready !== exp_id || req0_ready !== ~exp_id) begin errors++; $display("FAIL contention_grant job %0d got r0=%b r1=%b exp id %b", j, req0_ready, req1_ready, exp_id); end
         if (j > 0) begin
            checks++; if (waited !== 0) begin errors++; $display("FAIL contention_b2b job %0d got wait %0d exp 0", j, waited); end
         end
         @(negedge clk); #1;
         checks++; if (core_start !== 1'b1 || core_x !== (exp_id ? 16'h2222 : 16'h1111)) begin errors++; $display("FAIL contention_issue job %0d got start=%b x=%h", j, core_start, core_x); end
         @(negedge clk);
         core_done = 1'b1; core_xo = exp_id ? 16'hB000 : 16'hA000; core_yo = 16'h0; core_theta_o = 16'h0;
         @(negedge clk); core_done = 1'b0; #1;
         checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_x !== (exp_id ? 16'hB000 : 16'hA000)) begin errors++; $display("FAIL contention_rsp job %0d got vld=%b id=%b x=%h exp id %b", j, rsp_valid, rsp_id, rsp_x, exp_id); end
         rsp_ready = 1'b1;
         @(negedge clk); rsp_ready = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_illegal;
      int s0;
      req1_x = 16'h7777; req1_y = 16'h7777; req1_theta = 16'h7777; req1_sn = 4'd0; req1_valid = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL illegal_grant got %b exp 1", req1_ready); end
      s0 = start_cnt;
      @(negedge clk); req1_valid = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_rsp got vld=%b id=%b err=%b exp 1 1 1", rsp_valid, rsp_id, rsp_err); end
      checks++; if (rsp_x !== '0 || rsp_y !== '0 || rsp_theta !== '0) begin errors++; $display("FAIL illegal_data got %h %h %h exp 0", rsp_x, rsp_y, rsp_theta); end
      @(negedge clk); #1;
      checks++; if (start_cnt !== s0 || core_start !== 1'b0) begin errors++; $display("FAIL illegal_nostart got %0d pulses exp 0", start_cnt - s0); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
   endtask

   task automatic test_timeout;
      logic ok;
      req0_x = 16'h5555; req0_y = 16'h5555; req0_theta = 16'h5555; req0_sn = 4'd2; req0_valid = 1'b1;
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL timeout_grant got %b exp 1", req0_ready); end
      @(negedge clk); req0_valid = 1'b0; #1;
      checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL timeout_start got %b exp 1", core_start); end
      ok = 1'b1;
      repeat (TIMEOUT) begin @(negedge clk); #1; if (rsp_valid !== 1'b0) ok = 1'b0; end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL timeout_early got early rsp_valid, exp none before start+%0d", TIMEOUT + 1); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 1'b0) begin errors++; $display("FAIL timeout_rsp got vld=%b err=%b id=%b exp 1 1 0", rsp_valid, rsp_err, rsp_id); end
      checks++; if (rsp_x !== '0 || rsp_y !== '0 || rsp_theta !== '0) begin errors++; $display("FAIL timeout_data got %h %h %h exp 0", rsp_x, rsp_y, rsp_theta); end
      core_done = 1'b1; core_xo = 16'hFFFF; core_yo = 16'hFFFF; core_theta_o = 16'hFFFF;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_x !== '0 || rsp_theta !== '0) begin errors++; $display("FAIL timeout_late_done got vld=%b err=%b x=%h exp 1 1 0", rsp_valid, rsp_err, rsp_x); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      logic ok;
      req1_x = 16'h0102; req1_y = 16'h0304; req1_theta = 16'h0506; req1_sn = 4'd7; req1_valid = 1'b1;
      @(negedge clk); req1_valid = 1'b0;
      @(negedge clk);
      core_done = 1'b1; core_xo = 16'hCAFE; core_yo = 16'hBEEF; core_theta_o = 16'h0F0F;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_rsp got vld=%b id=%b exp 1 1", rsp_valid, rsp_id); end
      req0_valid = 1'b1; req1_valid = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         core_done = (i == 4); core_xo = 16'h1111;
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b0 || rsp_x !== 16'hCAFE ||
             rsp_y !== 16'hBEEF || rsp_theta !== 16'h0F0F || req0_ready !== 1'b0 || req1_ready !== 1'b0) ok = 1'b0;
      end
      core_done = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable=%b exp stable rsp and readys 0", ~ok); end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got vld=%b busy=%b exp 0 0", rsp_valid, busy); end
   endtask

   task automatic test_done_at_limit;
      req0_x = 16'h0A0A; req0_y = 16'h0B0B; req0_theta = 16'h0C0C; req0_sn = 4'd1; req0_valid = 1'b1;
      @(negedge clk); req0_valid = 1'b0;
      repeat (TIMEOUT - 1) @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL limit_early got vld=%b exp 0", rsp_valid); end
      @(negedge clk);
      core_done = 1'b1; core_xo = 16'h1357; core_yo = 16'h2468; core_theta_o = 16'h0ACE;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_x !== 16'h1357 || rsp_theta !== 16'h0ACE) begin errors++; $display("FAIL limit_rsp got vld=%b err=%b x=%h th=%h exp 1 0 1357 0ace", rsp_valid, rsp_err, rsp_x, rsp_theta); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait;
      req0_x = 16'h4321; req0_y = 16'h1; req0_theta = 16'h2; req0_sn = 4'd4; req0_valid = 1'b1;
      @(negedge clk); req0_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1; #1;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b vld=%b start=%b exp 0 0 0", busy, rsp_valid, core_start); end
      checks++; if (core_x !== '0 || core_sn !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_data got core_x=%h sn=%h id=%b err=%b exp 0", core_x, core_sn, rsp_id, rsp_err); end
      core_done = 1'b1; core_xo = 16'hDEAD;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_x !== '0) begin errors++; $display("FAIL midrst_late_done got vld=%b busy=%b x=%h exp 0 0 0", rsp_valid, busy, rsp_x); end
      req0_x = 16'h6543; req0_sn = 4'd5; req0_valid = 1'b1; #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_regrant got %b exp 1", req0_ready); end
      @(negedge clk); req0_valid = 1'b0; #1;
      checks++; if (core_start !== 1'b1 || core_x !== 16'h6543) begin errors++; $display("FAIL midrst_issue got start=%b x=%h exp 1 6543", core_start, core_x); end
      @(negedge clk);
      core_done = 1'b1; core_xo = 16'h7777; core_yo = 16'h0; core_theta_o = 16'h0;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_x !== 16'h7777) begin errors++; $display("FAIL midrst_rsp got vld=%b id=%b err=%b x=%h exp 1 0 0 7777", rsp_valid, rsp_id, rsp_err, rsp_x); end
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0; rsp_ready = 1'b0; core_done = 1'b0;
      core_xo = '0; core_yo = '0; core_theta_o = '0;
      req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_theta = '0; req0_sn = '0;
      req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_theta = '0; req1_sn = '0;
      @(negedge clk);
      test_reset;
      test_single;
      test_contention;
      test_illegal;
      test_timeout;
      test_backpressure;
      test_done_at_limit;
      test_reset_mid_wait;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
